// File: rtl/point_reconstructor.sv
// Point reconstructor: adds predictor output to decoded residuals, owns per-frame history,
// mode fallback and point indexing, and emits points through a one-deep valid/ready register.
module point_reconstructor #(
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned IDX_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic             in_eof,
    input  logic [1:0]       in_mode,
    input  logic [95:0]      in_res,
    output logic [1:0]       pred_mode,
    output logic [95:0]      pred_prev1,
    output logic [95:0]      pred_prev2,
    input  logic [95:0]      pred_point,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [95:0]      out_point,
    output logic             out_eof,
    output logic [IDX_W-1:0] out_index,
    output logic             fallback_sticky
);

    typedef enum logic [1:0] {HistNone, HistOne, HistTwo} hist_e;

    hist_e             state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [95:0]       out_point_q, out_point_d;
    logic              out_eof_q, out_eof_d;
    logic [IDX_W-1:0]  out_index_q, out_index_d;
    logic              sticky_q, sticky_d;
    logic [95:0]       prev1_q, prev1_d;
    logic [95:0]       prev2_q, prev2_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              accept;
    logic              no_hist;
    logic [95:0]       sum;
    logic [IDX_W-1:0]  cur_idx;
    logic [IDX_W-1:0]  idx_inc;

    // 33-bit add per axis; overflow shows up as bit 32 disagreeing with bit 31.
    function automatic logic [31:0] add_axis(input logic [31:0] p, input logic [31:0] r);
        logic [32:0] s;
        s = {p[31], p} + {r[31], r};
        if (SATURATE && (s[32] != s[31])) begin
            return s[32] ? 32'h8000_0000 : 32'h7fff_ffff;
        end
        return s[31:0];
    endfunction

    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign no_hist  = in_sof | (state_q == HistNone);
    assign cur_idx  = in_sof ? '0 : idx_q;
    assign idx_inc  = (&cur_idx) ? cur_idx : cur_idx + 1'b1;

    always_comb begin
        if (no_hist) begin
            pred_mode = 2'b10;
        end else if (state_q == HistOne && in_mode == 2'b01) begin
            pred_mode = 2'b00;
        end else begin
            pred_mode = in_mode;
        end
    end

    always_comb begin
        sum = '0;
        for (int a = 0; a < 3; a++) begin
            sum[a*32 +: 32] = add_axis(pred_point[a*32 +: 32], in_res[a*32 +: 32]);
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_point_d = out_point_q;
        out_eof_d   = out_eof_q;
        out_index_d = out_index_q;
        sticky_d    = sticky_q;
        prev1_d     = prev1_q;
        prev2_d     = prev2_q;
        idx_d       = idx_q;

        if (in_ready) begin
            out_valid_d = accept;
        end

        if (accept) begin
            out_point_d = sum;
            out_eof_d   = in_eof;
            out_index_d = cur_idx;
            prev2_d     = prev1_q;
            prev1_d     = sum;

            if (in_eof) begin
                state_d = HistNone;
                idx_d   = '0;
            end else begin
                state_d = no_hist ? HistOne : HistTwo;
                idx_d   = idx_inc;
            end

            // Only a requested 00/01 that got downgraded counts as a fallback.
            if (in_sof) begin
                sticky_d = 1'b0;
            end else if (!in_mode[1] && pred_mode != in_mode) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HistNone;
            out_valid_q <= 1'b0;
            out_point_q <= '0;
            out_eof_q   <= 1'b0;
            out_index_q <= '0;
            sticky_q    <= 1'b0;
            prev1_q     <= '0;
            prev2_q     <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_point_q <= out_point_d;
            out_eof_q   <= out_eof_d;
            out_index_q <= out_index_d;
            sticky_q    <= sticky_d;
            prev1_q     <= prev1_d;
            prev2_q     <= prev2_d;
            idx_q       <= idx_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_point       = out_point_q;
    assign out_eof         = out_eof_q;
    assign out_index       = out_index_q;
    assign fallback_sticky = sticky_q;
    assign pred_prev1      = prev1_q;
    assign pred_prev2      = prev2_q;

endmodule

// File: tb/tb_point_reconstructor.sv
// Bench for point_reconstructor: a wrapping and a saturating instance share one stimulus stream;
// a frame-level reference model feeds an expected-output queue drained by a monitor.
module tb_point_reconstructor;

    localparam int unsigned IW   = 3;
    localparam int          IMAX = (1 << IW) - 1;

    typedef struct {
        logic [95:0] p0;
        logic [95:0] p1;
        bit          eof;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sof, in_eof, out_ready;
    logic [1:0]  in_mode;
    logic [95:0] in_res;

    logic          in_ready [2];
    logic [1:0]    pred_mode [2];
    logic [95:0]   prev1 [2];
    logic [95:0]   prev2 [2];
    logic [95:0]   pred_point [2];
    logic          out_valid [2];
    logic [95:0]   out_point [2];
    logic          out_eof [2];
    logic [IW-1:0] out_index [2];
    logic          sticky [2];

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    int   stall_cycles = 0;
    bit   rnd_ready = 0;

    // Reference model state: last two reconstructed points per instance, points seen this frame.
    logic [95:0] mh1 [2];
    logic [95:0] mh2 [2];
    int          mhn;
    int          mcnt;
    bit          msticky;

    always #5 clk = ~clk;

    // Behavioural predictor attached to each DUT.
    function automatic logic [95:0] predict(input logic [1:0] m, input logic [95:0] p1,
                                            input logic [95:0] p2);
        logic [95:0] r;
        r = '0;
        if (m == 2'b00) begin
            r = p1;
        end else if (m == 2'b01) begin
            for (int a = 0; a < 3; a++) begin
                r[a*32 +: 32] = (p1[a*32 +: 32] << 1) - p2[a*32 +: 32];
            end
        end
        return r;
    endfunction

    function automatic logic [95:0] add_pt(input logic [95:0] p, input logic [95:0] r,
                                           input bit sat);
        logic [95:0] o;
        longint      s;
        o = '0;
        for (int a = 0; a < 3; a++) begin
            s = longint'($signed(p[a*32 +: 32])) + longint'($signed(r[a*32 +: 32]));
            if (sat && s > 64'sd2147483647) s = 64'sd2147483647;
            if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
            o[a*32 +: 32] = 32'(s);
        end
        return o;
    endfunction

    assign pred_point[0] = predict(pred_mode[0], prev1[0], prev2[0]);
    assign pred_point[1] = predict(pred_mode[1], prev1[1], prev2[1]);

    point_reconstructor #(.SATURATE(1'b0), .IDX_W(IW)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_sof(in_sof), .in_eof(in_eof), .in_mode(in_mode), .in_res(in_res),
        .pred_mode(pred_mode[0]), .pred_prev1(prev1[0]), .pred_prev2(prev2[0]),
        .pred_point(pred_point[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_point(out_point[0]), .out_eof(out_eof[0]), .out_index(out_index[0]),
        .fallback_sticky(sticky[0])
    );

    point_reconstructor #(.SATURATE(1'b1), .IDX_W(IW)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_sof(in_sof), .in_eof(in_eof), .in_mode(in_mode), .in_res(in_res),
        .pred_mode(pred_mode[1]), .pred_prev1(prev1[1]), .pred_prev2(prev2[1]),
        .pred_point(pred_point[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_point(out_point[1]), .out_eof(out_eof[1]), .out_index(out_index[1]),
        .fallback_sticky(sticky[1])
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mh1[i] = '0;
            mh2[i] = '0;
        end
        mhn     = 0;
        mcnt    = 0;
        msticky = 0;
        q.delete();
    endtask

    task automatic drive_ready();
        if (stall_cycles > 0) begin
            stall_cycles--;
            out_ready = 1'b0;
        end else begin
            out_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive_ready();
            in_valid = 1'b0;
            in_sof   = 1'($urandom);
            in_eof   = 1'($urandom);
            in_mode  = 2'($urandom);
            in_res   = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic send(input bit sof, input bit eof, input logic [1:0] mode,
                        input logic [95:0] res);
        bit          done;
        bit          exp_rdy;
        bit          h0;
        logic [1:0]  epm;
        int          idx;
        exp_t        e;
        logic [95:0] s;
        done = 0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            drive_ready();
            in_valid = 1'b1;
            in_sof   = sof;
            in_eof   = eof;
            in_mode  = mode;
            in_res   = res;
            #1;
            exp_rdy = (q.size() == 0) || out_ready;
            chk("in_ready wrap", 96'(in_ready[0]), 96'(exp_rdy));
            chk("in_ready sat", 96'(in_ready[1]), 96'(exp_rdy));
            if (exp_rdy) begin
                h0  = sof || (mhn == 0);
                epm = h0 ? 2'b10 : ((mhn == 1 && mode == 2'b01) ? 2'b00 : mode);
                if (sof) msticky = 0;
                else if (!mode[1] && epm != mode) msticky = 1;
                idx = sof ? 0 : mcnt;
                chk("pred_mode wrap", 96'(pred_mode[0]), 96'(epm));
                chk("pred_mode sat", 96'(pred_mode[1]), 96'(epm));
                for (int i = 0; i < 2; i++) begin
                    s = add_pt(predict(epm, mh1[i], mh2[i]), res, i == 1);
                    mh2[i] = mh1[i];
                    mh1[i] = s;
                end
                e.p0  = mh1[0];
                e.p1  = mh1[1];
                e.eof = eof;
                e.idx = idx;
                if (eof) begin
                    mhn  = 0;
                    mcnt = 0;
                end else begin
                    mhn  = h0 ? 1 : ((mhn < 2) ? mhn + 1 : 2);
                    mcnt = (idx == IMAX) ? idx : idx + 1;
                end
                @(posedge clk);
                q.push_back(e);
                #1;
                for (int i = 0; i < 2; i++) begin
                    chk("fallback_sticky", 96'(sticky[i]), 96'(msticky));
                    chk("pred_prev1", prev1[i], mh1[i]);
                    chk("pred_prev2", prev2[i], mh2[i]);
                end
                done = 1;
            end
        end
        if (!done) chk("accept timeout", 96'(0), 96'(1));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive_ready();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset out_valid", 96'(out_valid[i]), 96'(0));
            chk("reset out_point", out_point[i], 96'(0));
            chk("reset out_index", 96'(out_index[i]), 96'(0));
            chk("reset sticky", 96'(sticky[i]), 96'(0));
            chk("reset prev1", prev1[i], 96'(0));
            chk("reset prev2", prev2[i], 96'(0));
        end
        model_reset();
        @(negedge clk);
        drive_ready();
        rst_n = 1'b1;
    endtask

    function automatic logic [95:0] pt(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return {x, y, z};
    endfunction

    // Monitor: whenever an output is pending it must match the queue head; pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) continue;
            if (q.size() == 0) begin
                chk("idle out_valid wrap", 96'(out_valid[0]), 96'(0));
                chk("idle out_valid sat", 96'(out_valid[1]), 96'(0));
            end else begin
                e = q[0];
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("out_valid[%0d]", i), 96'(out_valid[i]), 96'(1));
                    chk($sformatf("out_point[%0d]", i), out_point[i], (i == 0) ? e.p0 : e.p1);
                    chk($sformatf("out_eof[%0d]", i), 96'(out_eof[i]), 96'(e.eof));
                    chk($sformatf("out_index[%0d]", i), 96'(out_index[i]), 96'(e.idx));
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        int drain;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_eof    = 1'b0;
        in_mode   = 2'b00;
        in_res    = '0;
        out_ready = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #10;
        for (int i = 0; i < 2; i++) begin
            chk("por out_valid", 96'(out_valid[i]), 96'(0));
            chk("por out_index", 96'(out_index[i]), 96'(0));
            chk("por sticky", 96'(sticky[i]), 96'(0));
            chk("por prev1", prev1[i], 96'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame: absolute start, previous-point, then linear.
        send(1, 0, 2'b00, pt(10, 20, 30));
        send(0, 0, 2'b00, pt(1, 1, 1));
        send(0, 0, 2'b01, pt(0, 0, 0));
        // Linear requested with one history point falls back and sets the flag.
        send(1, 0, 2'b00, pt(5, 5, 5));
        send(0, 0, 2'b01, pt(1, 0, 0));
        send(1, 0, 2'b10, pt(7, 8, 9));
        // Downstream stall with input held valid.
        stall_cycles = 3;
        send(0, 0, 2'b00, pt(2, 2, 2));
        send(0, 0, 2'b01, pt(3, 3, 3));
        send(0, 0, 2'b00, pt(4, 4, 4));
        // Overflow boundary in both directions.
        send(1, 0, 2'b10, pt(32'h7fff_ffff, 0, 0));
        send(0, 0, 2'b00, pt(1, 0, 0));
        send(1, 0, 2'b10, pt(32'h8000_0000, 0, 0));
        send(0, 0, 2'b00, pt(32'hffff_ffff, 0, 0));
        // Frame ending at index 4, then a new point without sof.
        send(1, 0, 2'b00, pt(1, 2, 3));
        for (int k = 0; k < 3; k++) send(0, 0, 2'b00, pt(1, 1, 1));
        send(0, 1, 2'b00, pt(1, 1, 1));
        send(0, 0, 2'b01, pt(9, 9, 9));
        send(1, 1, 2'b01, pt(4, 4, 4));
        // Long frame to reach index saturation.
        send(1, 0, 2'b00, pt(0, 0, 0));
        for (int k = 0; k < IMAX + 3; k++) send(0, 0, 2'b01, pt(1, 2, 3));
        // Reset while an output is pending.
        stall_cycles = 5;
        send(0, 0, 2'b00, pt(6, 6, 6));
        pulse_reset();
        stall_cycles = 0;
        send(0, 0, 2'b00, pt(1, 1, 1));

        rnd_ready = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
            send($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 2'($urandom),
                 ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, $urandom}
                                             : pt($urandom_range(0, 200) - 100,
                                                  $urandom_range(0, 200) - 100,
                                                  $urandom_range(0, 200) - 100));
        end

        rnd_ready = 0;
        drain = 0;
        while (q.size() != 0 && drain < 50) begin
            idle(1);
            drain++;
        end
        idle(2);
        chk("drain", 96'(q.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
